// File: rtl/udma_crc_seq.sv
// Burst sequencer for the UDMA CRC (X16+X12+X5+1): seeds, folds words, publishes and checks the peer CRC.
// Optional macro UDMA_CRC_ERRCNT_EN enables the saturating ERR_CNT burst error counter.
module udma_crc_seq #(
  parameter logic [15:0] SEED    = 16'h4580,
  parameter int          CNT_W   = 16,
  parameter int          TMO_CYC = 64
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             BURST_START,
  input  logic             BURST_END,
  input  logic             WORD_VLD,
  input  logic [15:0]      WORD,
  input  logic             CRC_IN_VLD,
  input  logic [15:0]      CRC_IN,
  output logic [15:0]      CRC_OUT,
  output logic             CRC_OUT_VLD,
  output logic             CRC_ERR,
  output logic             CRC_TMO,
  output logic             BUSY,
  output logic [CNT_W-1:0] WORD_CNT,
  output logic [7:0]       ERR_CNT
);

  localparam int TMO_W = $clog2(TMO_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, WAIT_CRC} state_t;

  state_t           state_q, state_d;
  logic [15:0]      crc_q, crc_d;
  logic [15:0]      crc_out_q, crc_out_d;
  logic             crc_out_vld_q, crc_out_vld_d;
  logic             crc_err_q, crc_err_d;
  logic             crc_tmo_q, crc_tmo_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Word-parallel CRC step: data bit 0 enters the MSB-first shift register first.
  function automatic logic [15:0] crc_cl(input logic [15:0] d, input logic [15:0] c);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 16; i++) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ ({16{fb}} & 16'h1021);
    end
    return r;
  endfunction

  always_comb begin
    state_d       = state_q;
    crc_d         = crc_q;
    crc_out_d     = crc_out_q;
    crc_out_vld_d = 1'b0;
    crc_err_d     = crc_err_q;
    crc_tmo_d     = crc_tmo_q;
    word_cnt_d    = word_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    // BURST_START takes priority in every state, including over a simultaneous BURST_END.
    if (BURST_START) begin
      state_d    = ACCUM;
      crc_d      = WORD_VLD ? crc_cl(WORD, SEED) : SEED;
      word_cnt_d = CNT_W'(WORD_VLD);
      crc_err_d  = 1'b0;
      crc_tmo_d  = 1'b0;
      tmo_cnt_d  = '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (WORD_VLD) begin
            crc_d      = crc_cl(WORD, crc_q);
            word_cnt_d = (word_cnt_q == '1) ? word_cnt_q : word_cnt_q + 1'b1;
          end
          if (BURST_END) begin
            crc_out_d     = crc_d;
            crc_out_vld_d = 1'b1;
            state_d       = WAIT_CRC;
            tmo_cnt_d     = '0;
          end
        end
        WAIT_CRC: begin
          if (CRC_IN_VLD) begin
            crc_err_d = (CRC_IN != crc_out_q);
            state_d   = IDLE;
          end else if (tmo_cnt_q == TMO_LAST) begin
            crc_tmo_d = 1'b1;
            state_d   = IDLE;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= IDLE;
      crc_q         <= SEED;
      crc_out_q     <= 16'h0000;
      crc_out_vld_q <= 1'b0;
      crc_err_q     <= 1'b0;
      crc_tmo_q     <= 1'b0;
      word_cnt_q    <= '0;
      tmo_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      crc_q         <= crc_d;
      crc_out_q     <= crc_out_d;
      crc_out_vld_q <= crc_out_vld_d;
      crc_err_q     <= crc_err_d;
      crc_tmo_q     <= crc_tmo_d;
      word_cnt_q    <= word_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

`ifdef UDMA_CRC_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       err_evt;

  // Flags are cleared at every burst start, so a rising flag is exactly one error event.
  always_comb begin
    err_evt   = (crc_err_d & ~crc_err_q) | (crc_tmo_d & ~crc_tmo_q);
    err_cnt_d = err_cnt_q;
    if (err_evt && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) err_cnt_q <= 8'h00;
    else        err_cnt_q <= err_cnt_d;
  end

  assign ERR_CNT = err_cnt_q;
`else
  assign ERR_CNT = 8'h00;
`endif

  assign CRC_OUT     = crc_out_q;
  assign CRC_OUT_VLD = crc_out_vld_q;
  assign CRC_ERR     = crc_err_q;
  assign CRC_TMO     = crc_tmo_q;
  assign BUSY        = (state_q != IDLE);
  assign WORD_CNT    = word_cnt_q;

endmodule

// File: tb/tb_udma_crc_seq.sv
// Bench for udma_crc_seq: vector table, directed multi-cycle sequences and random traffic vs a burst-level model.
module tb_udma_crc_seq;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        burst_start, burst_end, word_vld, crc_in_vld;
  logic [15:0] word, crc_in;
  logic [15:0] crc_out;
  logic        crc_out_vld, crc_err, crc_tmo, busy;
  logic [15:0] word_cnt;
  logic [7:0]  err_cnt;
  logic [15:0] crc_out4;
  logic        crc_out_vld4, crc_err4, crc_tmo4, busy4;
  logic [3:0]  word_cnt4;
  logic [7:0]  err_cnt4;

  always #5 clk = ~clk;

  udma_crc_seq dut (
    .CLK(clk), .RST_N(rst_n), .BURST_START(burst_start), .BURST_END(burst_end),
    .WORD_VLD(word_vld), .WORD(word), .CRC_IN_VLD(crc_in_vld), .CRC_IN(crc_in),
    .CRC_OUT(crc_out), .CRC_OUT_VLD(crc_out_vld), .CRC_ERR(crc_err), .CRC_TMO(crc_tmo),
    .BUSY(busy), .WORD_CNT(word_cnt), .ERR_CNT(err_cnt)
  );

  udma_crc_seq #(.CNT_W(4)) dut4 (
    .CLK(clk), .RST_N(rst_n), .BURST_START(burst_start), .BURST_END(burst_end),
    .WORD_VLD(word_vld), .WORD(word), .CRC_IN_VLD(crc_in_vld), .CRC_IN(crc_in),
    .CRC_OUT(crc_out4), .CRC_OUT_VLD(crc_out_vld4), .CRC_ERR(crc_err4), .CRC_TMO(crc_tmo4),
    .BUSY(busy4), .WORD_CNT(word_cnt4), .ERR_CNT(err_cnt4)
  );

  int n_vec = 0;
  int n_err = 0;

  // Burst-level reference model: words of the current burst kept in a queue.
  int          m_phase;          // 0 idle, 1 collecting words, 2 awaiting peer CRC
  logic [15:0] m_words[$];
  int          m_wait;
  logic [15:0] e_out;
  bit          e_vld, e_err, e_tmo;
  int          e_errcnt;

  // Bit-serial X16+X12+X5+1, data bit 0 first, seeded 0x4580.
  function automatic logic [15:0] crc_of(input logic [15:0] ws[$]);
    logic [15:0] c = 16'h4580;
    foreach (ws[k])
      for (int b = 0; b < 16; b++) begin
        bit top = c[15] ^ ws[k][b];
        c = c << 1;
        if (top) c = c ^ 16'h1021;
      end
    return c;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_words.delete(); m_wait = 0;
    e_out = 16'h0; e_vld = 0; e_err = 0; e_tmo = 0; e_errcnt = 0;
  endtask

  task automatic note_error();
    if (e_errcnt < 255) e_errcnt++;
  endtask

  task automatic model_step(input bit bs, be, wv, input logic [15:0] w, input bit cv, input logic [15:0] ci);
    e_vld = 0;
    if (bs) begin
      m_words.delete();
      if (wv) m_words.push_back(w);
      e_err = 0; e_tmo = 0; m_phase = 1;
    end else if (m_phase == 1) begin
      if (wv) m_words.push_back(w);
      if (be) begin
        e_out = crc_of(m_words); e_vld = 1; m_phase = 2; m_wait = 0;
      end
    end else if (m_phase == 2) begin
      if (cv) begin
        if (ci != e_out) begin e_err = 1; note_error(); end
        m_phase = 0;
      end else if (m_wait == TMO - 1) begin
        e_tmo = 1; note_error(); m_phase = 0;
      end else m_wait++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int sz = m_words.size();
    chk("crc_out", crc_out, e_out);
    chk("crc_out_vld", crc_out_vld, e_vld);
    chk("crc_err", crc_err, e_err);
    chk("crc_tmo", crc_tmo, e_tmo);
    chk("busy", busy, m_phase != 0);
    chk("word_cnt", word_cnt, (sz > 65535) ? 65535 : sz);
    chk("word_cnt4", word_cnt4, (sz > 15) ? 15 : sz);
`ifdef UDMA_CRC_ERRCNT_EN
    chk("err_cnt", err_cnt, e_errcnt);
`else
    chk("err_cnt", err_cnt, 0);
`endif
  endtask

  task automatic cycle(input bit bs, be, wv, input logic [15:0] w, input bit cv, input logic [15:0] ci);
    burst_start = bs; burst_end = be; word_vld = wv; word = w; crc_in_vld = cv; crc_in = ci;
    model_step(bs, be, wv, w, cv, ci);
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 16'h0, 0, 16'h0);
  endtask

  typedef struct {
    bit bs, be, wv; logic [15:0] w; bit cv; logic [15:0] ci;
    bit x_busy, x_vld, x_err; int x_cnt; logic [15:0] x_out;
  } vec_t;

  function automatic vec_t mk(bit bs, be, wv, logic [15:0] w, bit cv, logic [15:0] ci,
                              bit xb, xv, xe, int xc, logic [15:0] xo);
    vec_t v;
    v.bs = bs; v.be = be; v.wv = wv; v.w = w; v.cv = cv; v.ci = ci;
    v.x_busy = xb; v.x_vld = xv; v.x_err = xe; v.x_cnt = xc; v.x_out = xo;
    return v;
  endfunction

  initial begin
    vec_t        tbl[$];
    logic [15:0] two[$];
    logic [15:0] bw[$];
    logic [15:0] c2, w;
    int          n, lat;
    bit          wv;

    two.push_back(16'h1234); two.push_back(16'hABCD);
    c2 = crc_of(two);
    //            bs be wv w        cv ci          busy vld err cnt out
    tbl.push_back(mk(1, 0, 0, 16'h0,    0, 16'h0,      1, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 16'h0,    1, 16'hFFFF,   1, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 1, 0, 16'h0,    1, 16'h0000,   1, 1, 0, 0, 16'h4580));
    tbl.push_back(mk(0, 0, 0, 16'h0,    0, 16'h0,      1, 0, 0, 0, 16'h4580));
    tbl.push_back(mk(0, 0, 0, 16'h0,    1, 16'h4580,   0, 0, 0, 0, 16'h4580));
    tbl.push_back(mk(0, 0, 1, 16'h5555, 1, 16'h0000,   0, 0, 0, 0, 16'h4580));
    tbl.push_back(mk(1, 0, 1, 16'h1234, 0, 16'h0,      1, 0, 0, 1, 16'h4580));
    tbl.push_back(mk(0, 1, 1, 16'hABCD, 0, 16'h0,      1, 1, 0, 2, c2));
    tbl.push_back(mk(0, 0, 0, 16'h0,    1, c2 ^ 16'h1, 0, 0, 1, 2, c2));
    tbl.push_back(mk(0, 0, 0, 16'h0,    0, 16'h0,      0, 0, 1, 2, c2));
    tbl.push_back(mk(1, 0, 0, 16'h0,    0, 16'h0,      1, 0, 0, 0, c2));
    tbl.push_back(mk(0, 1, 0, 16'h0,    0, 16'h0,      1, 1, 0, 0, 16'h4580));

    burst_start = 0; burst_end = 0; word_vld = 0; word = 0; crc_in_vld = 0; crc_in = 0;
    rst_n = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge clk); rst_n = 1'b1;
    idle(2);

    foreach (tbl[i]) begin
      cycle(tbl[i].bs, tbl[i].be, tbl[i].wv, tbl[i].w, tbl[i].cv, tbl[i].ci);
      chk("tbl_busy", busy, tbl[i].x_busy);
      chk("tbl_vld", crc_out_vld, tbl[i].x_vld);
      chk("tbl_err", crc_err, tbl[i].x_err);
      chk("tbl_cnt", word_cnt, tbl[i].x_cnt);
      chk("tbl_out", crc_out, tbl[i].x_out);
    end

    // 256-word burst with gaps, words also in the START and END cycles
    w = 16'($urandom); bw.push_back(w);
    cycle(1, 0, 1, w, 0, 16'h0);
    n = 1;
    while (n < 255) begin
      wv = ($urandom_range(3) != 0);
      w = 16'($urandom);
      if (wv) begin bw.push_back(w); n++; end
      cycle(0, 0, wv, w, 0, 16'h0);
    end
    w = 16'($urandom); bw.push_back(w);
    cycle(0, 1, 1, w, 1, 16'hDEAD);
    chk("crc_256", crc_out, crc_of(bw));
    chk("cnt_256", word_cnt, 256);
    idle(3);
    cycle(0, 0, 0, 16'h0, 1, crc_of(bw));
    chk("err_256_match", crc_err, 0);

    // Same burst again, peer CRC off by one bit
    cycle(1, 0, 1, bw[0], 0, 16'h0);
    for (int i = 1; i < 255; i++) cycle(0, 0, 1, bw[i], 0, 16'h0);
    cycle(0, 1, 1, bw[255], 0, 16'h0);
    cycle(0, 0, 0, 16'h0, 1, crc_of(bw) ^ 16'h0001);
    chk("err_256_mismatch", crc_err, 1);
    cycle(1, 0, 0, 16'h0, 0, 16'h0);
    chk("err_cleared", crc_err, 0);

    // Timeout latency measured from the END edge
    cycle(0, 1, 0, 16'h0, 0, 16'h0);
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      cycle(0, 0, 0, 16'h0, 0, 16'h0);
      if (crc_tmo) begin lat = k; break; end
    end
    chk("tmo_latency", lat, TMO);
    chk("tmo_busy", busy, 0);

    // Compare on the final timeout cycle wins
    cycle(1, 0, 1, 16'h0F0F, 0, 16'h0);
    cycle(0, 1, 0, 16'h0, 0, 16'h0);
    idle(TMO - 1);
    cycle(0, 0, 0, 16'h0, 1, e_out);
    chk("last_cycle_tmo", crc_tmo, 0);
    chk("last_cycle_err", crc_err, 0);

    // Restart mid-burst: 10 words, START, 3 words, END (also exercises 4-bit counter saturation below)
    cycle(1, 0, 0, 16'h0, 0, 16'h0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, 16'($urandom), 0, 16'h0);
    cycle(1, 0, 0, 16'h0, 0, 16'h0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 16'($urandom), 0, 16'h0);
    cycle(0, 1, 0, 16'h0, 0, 16'h0);
    chk("restart_cnt", word_cnt, 3);

    // START in WAIT_CRC, then START+END together, then 20 words for saturation
    cycle(1, 0, 0, 16'h0, 0, 16'h0);
    cycle(1, 1, 1, 16'h7777, 0, 16'h0);
    chk("start_wins_vld", crc_out_vld, 0);
    for (int i = 0; i < 19; i++) cycle(0, 0, 1, 16'($urandom), 0, 16'h0);
    chk("cnt4_sat", word_cnt4, 4'hF);
    chk("cnt16_20", word_cnt, 20);

    // Asynchronous reset mid-ACCUM
    #3 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    idle(1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit rcv = ($urandom_range(5) == 0);
      cycle($urandom_range(60) == 0, $urandom_range(20) == 0, $urandom_range(2) != 0,
            16'($urandom), rcv, ($urandom_range(1) == 0) ? e_out : 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
